// File: rtl/byteswap_sched_pkg.sv
// byteswap_sched shared types: slot state encoding and port tags.
// Imported by the arbiter and the top (import byteswap_pkg::*).
package byteswap_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL32 = 2'd1,
        FULL64 = 2'd2
    } state_t;

    localparam logic PORT32 = 1'b0;
    localparam logic PORT64 = 1'b1;

endpackage

// File: rtl/byteswap_sched_if.sv
// Request/response channels of byteswap_sched (32-bit and 64-bit ports).
// master = requester/consumer side, slave = byteswap_sched side.
interface byteswap_sched_if;

    logic        req32_valid;
    logic [31:0] req32_data;
    logic        req32_ready;
    logic        req64_valid;
    logic [63:0] req64_data;
    logic        req64_ready;
    logic        rsp32_valid;
    logic [31:0] rsp32_data;
    logic        rsp32_ready;
    logic        rsp64_valid;
    logic [63:0] rsp64_data;
    logic        rsp64_ready;

    modport master (
        output req32_valid, req32_data,
        input  req32_ready,
        output req64_valid, req64_data,
        input  req64_ready,
        input  rsp32_valid, rsp32_data,
        output rsp32_ready,
        input  rsp64_valid, rsp64_data,
        output rsp64_ready
    );

    modport slave (
        input  req32_valid, req32_data,
        output req32_ready,
        input  req64_valid, req64_data,
        output req64_ready,
        output rsp32_valid, rsp32_data,
        input  rsp32_ready,
        output rsp64_valid, rsp64_data,
        input  rsp64_ready
    );

endinterface

// File: rtl/byteswap64.sv
// Combinational 64-bit byte reversal.
// Ports: i_data in 64, o_data out 64 (byte 0 <-> byte 7, ...).
module byteswap64 (
    input  logic [63:0] i_data,
    output logic [63:0] o_data
);

    for (genvar g = 0; g < 8; g++) begin : g_byte
        assign o_data[8*g +: 8] = i_data[8*(7-g) +: 8];
    end

endmodule

// File: rtl/byteswap_sched_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter, pointer moves only on accept.
// Ports: clk, rst_n, i_free, i_req0/1 in; o_rdy0/1, o_acc, o_port out.
module rr_arb2
    import byteswap_pkg::*;
#(
    parameter logic PRIO = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_free,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_rdy0,
    output logic o_rdy1,
    output logic o_acc,
    output logic o_port
);

    // r_ptr names the port that wins the next contest.
    logic r_ptr;
    logic w_acc0;
    logic w_acc1;

    // Each ready looks only at the other port's valid, so a ready
    // never depends on its own valid.
    assign o_rdy0 = i_free & (~i_req1 | (r_ptr == PORT32));
    assign o_rdy1 = i_free & (~i_req0 | (r_ptr == PORT64));
    assign w_acc0 = i_req0 & o_rdy0;
    assign w_acc1 = i_req1 & o_rdy1;
    assign o_acc  = w_acc0 | w_acc1;
    assign o_port = w_acc1 ? PORT64 : PORT32;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PRIO;
        end else if (o_acc) begin
            r_ptr <= ~o_port;
        end
    end

endmodule

// File: rtl/byteswap_sched.sv
// byteswap_sched: one byteswap64 shared by a 32-bit and a 64-bit port,
// round-robin arbitrated, one-deep registered result slot.
// Ports: clk, rst_n, bus (byteswap_sched_if.slave), busy,
// cnt32/cnt64/stall_cnt (CNT_W, live only with BYTESWAP_SCHED_STATS_EN).
module byteswap_sched
    import byteswap_pkg::*;
#(
    parameter int PRIO_64 = 0,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    byteswap_sched_if.slave    bus,
    output logic               busy,
    output logic [CNT_W-1:0]   cnt32,
    output logic [CNT_W-1:0]   cnt64,
    output logic [CNT_W-1:0]   stall_cnt
);

    state_t      r_state;
    logic [63:0] r_slot;
    logic        w_hs32;
    logic        w_hs64;
    logic        w_free;
    logic        w_acc;
    logic        w_port;
    logic [63:0] w_mux;
    logic [63:0] w_swap;

    assign w_hs32 = bus.rsp32_valid & bus.rsp32_ready;
    assign w_hs64 = bus.rsp64_valid & bus.rsp64_ready;
    // Slot drains and refills in the same cycle; gated by rst_n so the
    // request readies read 0 while reset is held.
    assign w_free = rst_n & ((r_state == EMPTY) | w_hs32 | w_hs64);

    rr_arb2 #(
        .PRIO (PRIO_64 != 0)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_free (w_free),
        .i_req0 (bus.req32_valid),
        .i_req1 (bus.req64_valid),
        .o_rdy0 (bus.req32_ready),
        .o_rdy1 (bus.req64_ready),
        .o_acc  (w_acc),
        .o_port (w_port)
    );

    assign w_mux = (w_port == PORT64) ? bus.req64_data
                                      : {32'h0, bus.req32_data};

    byteswap64 u_swap (
        .i_data (w_mux),
        .o_data (w_swap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_slot  <= '0;
        end else if (w_free) begin
            if (w_acc) begin
                r_state <= (w_port == PORT64) ? FULL64 : FULL32;
                r_slot  <= w_swap;
            end else begin
                r_state <= EMPTY;
            end
        end
    end

    assign bus.rsp32_valid = (r_state == FULL32);
    assign bus.rsp64_valid = (r_state == FULL64);
    // A 32-bit word sits in the low half of the mux, so its swap
    // lands in the high half.
    assign bus.rsp32_data  = r_slot[63:32];
    assign bus.rsp64_data  = r_slot;
    assign busy            = (r_state != EMPTY);

`ifdef BYTESWAP_SCHED_STATS_EN
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt32;
    logic [CNT_W-1:0] r_cnt64;
    logic [CNT_W-1:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt32 <= '0;
            r_cnt64 <= '0;
            r_stall <= '0;
        end else begin
            if (w_hs32) r_cnt32 <= r_cnt32 + C_ONE;
            if (w_hs64) r_cnt64 <= r_cnt64 + C_ONE;
            if ((bus.rsp32_valid & ~bus.rsp32_ready) |
                (bus.rsp64_valid & ~bus.rsp64_ready))
                r_stall <= r_stall + C_ONE;
        end
    end

    assign cnt32     = r_cnt32;
    assign cnt64     = r_cnt64;
    assign stall_cnt = r_stall;
`else
    assign cnt32     = '0;
    assign cnt64     = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_byteswap_sched.sv
// Scoreboard bench for byteswap_sched: directed cases plus random traffic
// checked against a byte-order reference model and a round-robin model.
module tb_byteswap_sched;

    localparam int PRIO_64 = 0;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] cnt32;
    logic [CNT_W-1:0] cnt64;
    logic [CNT_W-1:0] stall_cnt;

    byteswap_sched_if bus();

    byteswap_sched #(
        .PRIO_64 (PRIO_64),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .cnt32     (cnt32),
        .cnt64     (cnt64),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q32[$];
    logic [63:0] q64[$];
    int          last_win;
    int          n32, n64, nstall;
    bit          acc32, acc64;
    bit          pv32, pv64, pr32, pr64;
    logic [31:0] pd32;
    logic [63:0] pd64;

    function automatic logic [63:0] ref_swap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[63-8*i -: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        acc32 = 0;
        acc64 = 0;
        q32.delete();
        q64.delete();
        last_win = (PRIO_64 != 0) ? 0 : 1;
        n32 = 0;
        n64 = 0;
        nstall = 0;
        pv32 = 0;
        pv64 = 0;
    endtask

    task automatic check_reset_outs();
        chk("reset_ctl", {bus.rsp32_valid, bus.rsp64_valid,
            bus.req32_ready, bus.req64_ready, busy}, 0);
        chk("reset_d32", bus.rsp32_data, 0);
        chk("reset_d64", bus.rsp64_data, 0);
        chk("reset_cnt", {cnt32, cnt64, stall_cnt}, 0);
    endtask

    task automatic send32(input logic [31:0] d);
        bus.req32_valid = 1'b1;
        bus.req32_data  = d;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (acc32) break;
        end
        chk("send32_accept", acc32, 1);
        bus.req32_valid = 1'b0;
    endtask

    task automatic check_stats();
`ifdef BYTESWAP_SCHED_STATS_EN
        chk("cnt32", cnt32, CNT_W'(n32));
        chk("cnt64", cnt64, CNT_W'(n64));
        chk("stall_cnt", stall_cnt, CNT_W'(nstall));
`else
        chk("cnt_tied0", {cnt32, cnt64, stall_cnt}, 0);
`endif
    endtask

    // Request side: accepts, arbitration model, expected-result pushes.
    always @(negedge clk) begin
        if (rst_n) begin
            bit hold;
            acc32 = bus.req32_valid & bus.req32_ready;
            acc64 = bus.req64_valid & bus.req64_ready;
            hold  = (bus.rsp32_valid & ~bus.rsp32_ready) |
                    (bus.rsp64_valid & ~bus.rsp64_ready);
            if (hold)
                chk("ready_blocked", {bus.req32_ready, bus.req64_ready}, 0);
            else if (bus.req32_valid | bus.req64_valid)
                chk("free_accept", acc32 | acc64, 1);
            if (bus.req32_valid && bus.req64_valid && !hold)
                chk("rr_winner", {acc32, acc64},
                    (last_win == 1) ? 2'b10 : 2'b01);
            if (acc32) begin
                q32.push_back(ref_swap32(bus.req32_data));
                last_win = 0;
            end
            if (acc64) begin
                q64.push_back(ref_swap64(bus.req64_data));
                last_win = 1;
            end
        end
    end

    // Response monitor: pops and compares on each response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, bus.rsp32_valid | bus.rsp64_valid);
            if (bus.rsp32_valid && bus.rsp64_valid)
                chk("both_valid", 1, 0);
            if (pv32 && !pr32) begin
                chk("hold32_valid", bus.rsp32_valid, 1);
                chk("hold32_data", bus.rsp32_data, pd32);
            end
            if (pv64 && !pr64) begin
                chk("hold64_valid", bus.rsp64_valid, 1);
                chk("hold64_data", bus.rsp64_data, pd64);
            end
            if (bus.rsp32_valid && bus.rsp32_ready) begin
                n32++;
                if (q32.size() == 0) chk("rsp32_spurious", 1, 0);
                else chk("rsp32_data", bus.rsp32_data, q32.pop_front());
            end
            if (bus.rsp64_valid && bus.rsp64_ready) begin
                n64++;
                if (q64.size() == 0) chk("rsp64_spurious", 1, 0);
                else chk("rsp64_data", bus.rsp64_data, q64.pop_front());
            end
            if ((bus.rsp32_valid && !bus.rsp32_ready) ||
                (bus.rsp64_valid && !bus.rsp64_ready))
                nstall++;
            pv32 = bus.rsp32_valid;
            pr32 = bus.rsp32_ready;
            pd32 = bus.rsp32_data;
            pv64 = bus.rsp64_valid;
            pr64 = bus.rsp64_ready;
            pd64 = bus.rsp64_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CNT_W-1:0] sbase;
        bus.req32_valid = 1'b0;
        bus.req32_data  = '0;
        bus.req64_valid = 1'b0;
        bus.req64_data  = '0;
        bus.rsp32_ready = 1'b1;
        bus.rsp64_ready = 1'b1;
        assert_reset();
        #12;
        check_reset_outs();
        tick();
        rst_n = 1'b1;
        tick();

        // Simultaneous requests: grants alternate 32,64,... one per clock.
        bus.req32_valid = 1'b1;
        bus.req32_data  = $urandom;
        bus.req64_valid = 1'b1;
        bus.req64_data  = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("alt_acc32", acc32, (i % 2) == 0);
            chk("alt_acc64", acc64, (i % 2) == 1);
            if (acc32) bus.req32_data = $urandom;
            if (acc64) bus.req64_data = {$urandom, $urandom};
        end
        bus.req32_valid = 1'b0;
        bus.req64_valid = 1'b0;
        tick();
        tick();

        // Single 32-bit request.
        send32(32'h11223344);
        chk("lat32_valid", bus.rsp32_valid, 1);
        chk("lat32_data", bus.rsp32_data, 32'h44332211);
        tick();
        chk("rsp32_done", bus.rsp32_valid, 0);

        // Single 64-bit request.
        bus.req64_valid = 1'b1;
        bus.req64_data  = 64'h0102030405060708;
        tick();
        chk("acc64_single", acc64, 1);
        bus.req64_valid = 1'b0;
        chk("lat64_valid", bus.rsp64_valid, 1);
        chk("lat64_data", bus.rsp64_data, 64'h0807060504030201);
        chk("lat64_no32", bus.rsp32_valid, 0);
        tick();

        // Backpressure on a 64-bit result for 5 cycles.
        bus.rsp64_ready = 1'b0;
        bus.req64_valid = 1'b1;
        bus.req64_data  = {$urandom, $urandom};
        tick();
        chk("bp_acc64", acc64, 1);
        bus.req64_valid = 1'b0;
        bus.req32_valid = 1'b1;
        bus.req32_data  = $urandom;
        sbase = stall_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_no_grant", acc32, 0);
        end
`ifdef BYTESWAP_SCHED_STATS_EN
        chk("bp_stall5", stall_cnt - sbase, 5);
`else
        chk("bp_stall_tied0", stall_cnt, 0);
`endif
        bus.rsp64_ready = 1'b1;
        tick();
        chk("bp_grant_after", acc32, 1);
        bus.req32_valid = 1'b0;
        tick();
        tick();
        check_stats();

        // Counter wrap: 17 completed 32-bit transfers from reset.
        assert_reset();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) send32($urandom);
        tick();
        tick();
`ifdef BYTESWAP_SCHED_STATS_EN
        chk("cnt32_wrap", cnt32, 1);
`else
        chk("cnt32_tied0", cnt32, 0);
`endif
        check_stats();

        // Reset while a 32-bit result is held.
        bus.rsp32_ready = 1'b0;
        send32(32'hDEADBEEF);
        chk("mid_full32", bus.rsp32_valid, 1);
        #2;
        assert_reset();
        #1;
        check_reset_outs();
        tick();
        tick();
        rst_n = 1'b1;
        bus.rsp32_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_rsp_after_reset", {bus.rsp32_valid, bus.rsp64_valid}, 0);
        end
        bus.req32_valid = 1'b1;
        bus.req32_data  = $urandom;
        bus.req64_valid = 1'b1;
        bus.req64_data  = {$urandom, $urandom};
        tick();
        chk("prio_after_reset", {acc32, acc64},
            (PRIO_64 != 0) ? 2'b01 : 2'b10);
        bus.req32_valid = 1'b0;
        bus.req64_valid = 1'b0;
        tick();
        tick();

        // Random traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            if (!bus.req32_valid || acc32) begin
                bus.req32_valid = ($urandom % 3) != 0;
                bus.req32_data  = $urandom;
            end
            if (!bus.req64_valid || acc64) begin
                bus.req64_valid = ($urandom % 3) != 0;
                bus.req64_data  = {$urandom, $urandom};
            end
            bus.rsp32_ready = ($urandom % 4) != 0;
            bus.rsp64_ready = ($urandom % 4) != 0;
            tick();
        end
        bus.req32_valid = 1'b0;
        bus.req64_valid = 1'b0;
        bus.rsp32_ready = 1'b1;
        bus.rsp64_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("drain32", q32.size(), 0);
        chk("drain64", q64.size(), 0);
        chk("idle_busy", busy, 0);
        check_stats();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byteswap_sched.md
Name: byteswap_sched

Overview:
- Shares one byteswap64 datapath between a 32-bit requester and a 64-bit requester.
- Arbitrates between them round-robin and registers the swapped result in a one-deep output slot.
- Returns each result on the response channel of the port that issued it, using valid/ready handshakes on every channel.
- Sits between the host-side packet formatter and the endian-sensitive register/stream paths.

Parameters:
- PRIO_64, 0: port that wins the first simultaneous request after reset; 0 = 32-bit port, 1 = 64-bit port.
- CNT_W, 16: width of the statistics counters. Used only with BYTESWAP_SCHED_STATS_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req32_valid  in  1  32-bit request valid.
- req32_data  in  32  32-bit word to swap.
- req32_ready  out  1  32-bit request accepted this cycle.
- req64_valid  in  1  64-bit request valid.
- req64_data  in  64  64-bit word to swap.
- req64_ready  out  1  64-bit request accepted this cycle.
- rsp32_valid  out  1  32-bit result valid.
- rsp32_data  out  32  byte-reversed req32_data.
- rsp32_ready  in  1  32-bit consumer ready.
- rsp64_valid  out  1  64-bit result valid.
- rsp64_data  out  64  byte-reversed req64_data.
- rsp64_ready  in  1  64-bit consumer ready.
- busy  out  1  output slot occupied.
- cnt32  out  CNT_W  completed 32-bit transfers (stats build only).
- cnt64  out  CNT_W  completed 64-bit transfers (stats build only).
- stall_cnt  out  CNT_W  cycles a result was held under backpressure (stats build only).

Behaviour:
- Reset:
  - asynchronous, active-low; all outputs go to 0.
  - State goes to EMPTY.
  - Round-robin pointer loads PRIO_64.
  - Slot data clears to 0.
- Slot state machine:
  - EMPTY: grant on any valid request. Go to FULL32 or FULL64 according to the winner.
  - FULL32: rsp32_valid=1. On rsp32_ready:
    - grant pending → go to FULL32/FULL64;
    - no grant → go to EMPTY.
  - FULL64: same as FULL32, using rsp64_valid and rsp64_ready.
- Slot free = EMPTY, or FULLx with the matching rsp ready high in the same cycle. This gives full throughput of 1 transfer/clk.
- Arbitration and ready rules:
  - reqX_ready is combinational: slot free AND port X is granted.
  - reqX_ready may depend on the other port's valid. It never depends on reqX_valid.
  - Single requester: that port is granted.
  - Both requesting: the port not granted last time wins.
  - The pointer updates only on an accepted transfer, never on idle cycles.
- Latency: accepted at edge N → rsp valid after edge N, data stable until handshake.
- Datapath:
  - one shared byteswap64 instance; its mux input is req64_data or {32'h0, req32_data}.
  - rsp32_data = byteswap64 output [63:32]; rsp64_data = full output.
  - Result is captured into a registered slot.
- Response outputs hold data and valid, unchanged, while ready is low (AXI-style). rspX_data is valid only when rspX_valid=1.
- Never both rsp valids at once; busy = (state != EMPTY).
- Reset mid-transfer: the pending result is discarded and no response is issued afterwards.

Optional Feature:
- Macro: BYTESWAP_SCHED_STATS_EN.
- Defined:
  - cnt32/cnt64 increment on each completed response handshake of their port.
  - stall_cnt increments each cycle a rsp valid is high with its ready low.
  - All three counters wrap at 2^CNT_W and reset to 0.
- Undefined:
  - counter logic is absent; cnt32, cnt64 and stall_cnt are tied to 0.
  - Ports remain for pin compatibility.

Decomposition:
- Package byteswap_pkg holds:
  - state encoding EMPTY=2'd0, FULL32=2'd1, FULL64=2'd2;
  - port tags PORT32=1'b0, PORT64=1'b1.
- Natural sub-module: rr_arb2, the 2-way round-robin arbiter with a pointer register and a grant-on-accept update.
- byteswap64 is instantiated unchanged.

Test Plan:
- 32-bit single: req32_data=32'h11223344, rsp32_ready=1 → rsp32_valid one cycle after accept, rsp32_data=32'h44332211.
- 64-bit single: req64_data=64'h0102030405060708 → rsp64_data=64'h0807060504030201; rsp32_valid stays 0.
- Simultaneous, PRIO_64=0: both valid continuously, both rsp ready=1 → grants alternate 32,64,32,64, one result/clk.
- Backpressure: 64-bit result with rsp64_ready=0 for 5 cycles → data/valid stable; both req_ready=0; stall_cnt=5 (stats build); the next grant goes only after ready rises.
- Reset mid-op: assert rst_n=0 while in FULL32 → all outputs 0 immediately, no response after release, first simultaneous grant goes to the PRIO_64 port.
- Stats wrap with CNT_W=4: complete 17 32-bit transfers → cnt32=1; non-stats build → counters read 0.
